// File: rtl/shared_reg_arbiter_if.sv
// Bus between the four requesters and the shared register arbiter.
// The master side drives requests and write data; the slave side returns grant and register state.
interface shared_reg_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]       req;
    logic [WIDTH-1:0] wdata0;
    logic [WIDTH-1:0] wdata1;
    logic [WIDTH-1:0] wdata2;
    logic [WIDTH-1:0] wdata3;
    logic [3:0]       gnt;
    logic [3:0]       ack;
    logic             ce;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [1:0]       owner;
    logic             busy;

    modport master (
        output req, wdata0, wdata1, wdata2, wdata3,
        input  gnt, ack, ce, d, q, owner, busy
    );

    modport slave (
        input  req, wdata0, wdata1, wdata2, wdata3,
        output gnt, ack, ce, d, q, owner, busy
    );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one falling-edge register among four requesters.
// An owner holds the register for up to MAX_HOLD writes, then priority rotates past it.
module shared_reg_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk_n,
    input  logic                 clr_n,
    shared_reg_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [2:0] HOLD_LAST = 3'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       last_q, last_d;
    logic [2:0]       hold_q, hold_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic             pick_vld;
    logic [1:0]       pick_idx;
    logic [1:0]       cand;
    logic [WIDTH-1:0] wsel;
    logic             own_req;

    // Scan starts just after the last released owner, so it has lowest priority.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = last_q;
        cand     = last_q;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!pick_vld && bus.req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        wsel = bus.wdata0;
        case (owner_q)
            2'd0: wsel = bus.wdata0;
            2'd1: wsel = bus.wdata1;
            2'd2: wsel = bus.wdata2;
            2'd3: wsel = bus.wdata3;
            default: wsel = bus.wdata0;
        endcase
    end

    assign own_req = bus.req[owner_q];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d   = 4'b0001 << pick_idx;
                    owner_d = pick_idx;
                    hold_d  = 3'd0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Last allowed write and release share one edge; a dropped req releases without writing.
                if (own_req) begin
                    data_d = wsel;
                    hold_d = hold_q + 3'd1;
                end
                if (!own_req || hold_q == HOLD_LAST) begin
                    last_d  = owner_q;
                    gnt_d   = 4'b0000;
                    hold_d  = 3'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge clk_n or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            owner_q <= 2'd0;
            last_q  <= 2'd3;
            hold_q  <= 3'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
        end
    end

    assign bus.busy  = (state_q == GRANT);
    assign bus.gnt   = gnt_q;
    assign bus.ack   = gnt_q & bus.req;
    assign bus.ce    = bus.busy & own_req;
    assign bus.d     = bus.busy ? wsel : '0;
    assign bus.q     = data_q;
    assign bus.owner = owner_q;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: vector table with a post-edge scoreboard,
// plus hand-written reset, rotation and mid-grant reset sequences.
module tb_shared_reg_arbiter;
    logic clk_n;
    logic clr_n;
    int   checks = 0;
    int   errors = 0;

    shared_reg_arbiter_if #(.WIDTH(8)) bus();

    shared_reg_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
        .clk_n (clk_n),
        .clr_n (clr_n),
        .bus   (bus.slave)
    );

    initial begin
        clk_n = 1'b1;
        forever #5 clk_n = ~clk_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] req;
        logic [7:0] w0, w1, w2, w3;
        logic [3:0] ack;
        logic       ce;
        logic [7:0] d;
        logic [3:0] gnt;
        logic [7:0] q;
        logic [1:0] owner;
        logic       busy;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] q;
        logic [1:0] owner;
        logic       busy;
    } post_t;

    vec_t  vecs[23];
    post_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] e);
        bus.req = r; bus.wdata0 = a; bus.wdata1 = b; bus.wdata2 = c; bus.wdata3 = e;
    endtask

    task automatic edge_sample();
        @(negedge clk_n);
        #1;
    endtask

    task automatic reset_dut();
        edge_sample();
        drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        clr_n = 1'b0;
        #2;
        clr_n = 1'b1;
    endtask

    initial begin
        logic [1:0] rot [5];
        post_t      exp_p;
        post_t      got_p;

        vecs[0]  = '{4'b0100, 8'h00, 8'h00, 8'h11, 8'h00, 4'b0000, 1'b0, 8'h00, 4'b0100, 8'h00, 2'd2, 1'b1};
        vecs[1]  = '{4'b0100, 8'h00, 8'h00, 8'h11, 8'h00, 4'b0100, 1'b1, 8'h11, 4'b0100, 8'h11, 2'd2, 1'b1};
        vecs[2]  = '{4'b0100, 8'h00, 8'h00, 8'h12, 8'h00, 4'b0100, 1'b1, 8'h12, 4'b0100, 8'h12, 2'd2, 1'b1};
        vecs[3]  = '{4'b0100, 8'h00, 8'h00, 8'h13, 8'h00, 4'b0100, 1'b1, 8'h13, 4'b0100, 8'h13, 2'd2, 1'b1};
        vecs[4]  = '{4'b0100, 8'h00, 8'h00, 8'h14, 8'h00, 4'b0100, 1'b1, 8'h14, 4'b0000, 8'h14, 2'd2, 1'b0};
        vecs[5]  = '{4'b0100, 8'h00, 8'h00, 8'h15, 8'h00, 4'b0000, 1'b0, 8'h00, 4'b0100, 8'h14, 2'd2, 1'b1};
        vecs[6]  = '{4'b0100, 8'h00, 8'h00, 8'h15, 8'h00, 4'b0100, 1'b1, 8'h15, 4'b0100, 8'h15, 2'd2, 1'b1};
        vecs[7]  = '{4'b0100, 8'h00, 8'h00, 8'h16, 8'h00, 4'b0100, 1'b1, 8'h16, 4'b0100, 8'h16, 2'd2, 1'b1};
        vecs[8]  = '{4'b0000, 8'h00, 8'h00, 8'h16, 8'h00, 4'b0000, 1'b0, 8'h16, 4'b0000, 8'h16, 2'd2, 1'b0};
        vecs[9]  = '{4'b0010, 8'h44, 8'hA5, 8'h16, 8'h33, 4'b0000, 1'b0, 8'h00, 4'b0010, 8'h16, 2'd1, 1'b1};
        vecs[10] = '{4'b1011, 8'h44, 8'hA5, 8'h16, 8'h33, 4'b0010, 1'b1, 8'hA5, 4'b0010, 8'hA5, 2'd1, 1'b1};
        vecs[11] = '{4'b1001, 8'h44, 8'hA5, 8'h16, 8'h33, 4'b0000, 1'b0, 8'hA5, 4'b0000, 8'hA5, 2'd1, 1'b0};
        vecs[12] = '{4'b1001, 8'h44, 8'hA5, 8'h16, 8'h33, 4'b0000, 1'b0, 8'h00, 4'b1000, 8'hA5, 2'd3, 1'b1};
        vecs[13] = '{4'b1001, 8'h44, 8'hA5, 8'h16, 8'h33, 4'b1000, 1'b1, 8'h33, 4'b1000, 8'h33, 2'd3, 1'b1};
        vecs[14] = '{4'b0001, 8'h44, 8'hA5, 8'h16, 8'h33, 4'b0000, 1'b0, 8'h33, 4'b0000, 8'h33, 2'd3, 1'b0};
        vecs[15] = '{4'b0001, 8'h44, 8'hA5, 8'h16, 8'h33, 4'b0000, 1'b0, 8'h00, 4'b0001, 8'h33, 2'd0, 1'b1};
        vecs[16] = '{4'b1001, 8'h44, 8'hA5, 8'h16, 8'hFF, 4'b0001, 1'b1, 8'h44, 4'b0001, 8'h44, 2'd0, 1'b1};
        vecs[17] = '{4'b0001, 8'h45, 8'hA5, 8'h16, 8'hFF, 4'b0001, 1'b1, 8'h45, 4'b0001, 8'h45, 2'd0, 1'b1};
        vecs[18] = '{4'b1001, 8'h46, 8'hA5, 8'h16, 8'hFF, 4'b0001, 1'b1, 8'h46, 4'b0001, 8'h46, 2'd0, 1'b1};
        vecs[19] = '{4'b1001, 8'h47, 8'hA5, 8'h16, 8'hFF, 4'b0001, 1'b1, 8'h47, 4'b0000, 8'h47, 2'd0, 1'b0};
        vecs[20] = '{4'b1000, 8'h47, 8'hA5, 8'h16, 8'hFF, 4'b0000, 1'b0, 8'h00, 4'b1000, 8'h47, 2'd3, 1'b1};
        vecs[21] = '{4'b1000, 8'h47, 8'hA5, 8'h16, 8'hFF, 4'b1000, 1'b1, 8'hFF, 4'b1000, 8'hFF, 2'd3, 1'b1};
        vecs[22] = '{4'b0000, 8'h47, 8'hA5, 8'h16, 8'hFF, 4'b0000, 1'b0, 8'hFF, 4'b0000, 8'hFF, 2'd3, 1'b0};

        // Reset with random activity on the inputs.
        clr_n = 1'b0;
        drive(4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        repeat (3) edge_sample();
        drive(4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        #1;
        chk("rst_gnt",   32'(bus.gnt),   32'h0);
        chk("rst_ack",   32'(bus.ack),   32'h0);
        chk("rst_ce",    32'(bus.ce),    32'h0);
        chk("rst_d",     32'(bus.d),     32'h0);
        chk("rst_busy",  32'(bus.busy),  32'h0);
        chk("rst_owner", 32'(bus.owner), 32'h0);
        chk("rst_q",     32'(bus.q),     32'h0);
        drive(4'b0001, 8'h00, 8'h00, 8'h00, 8'h00);
        #1 clr_n = 1'b1;
        edge_sample();
        chk("rst_release_gnt", 32'(bus.gnt), 32'h1);

        // Vector table, post-edge expectations through the scoreboard.
        reset_dut();
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].req, vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].w3);
            #1;
            chk($sformatf("v%0d_ack", i), 32'(bus.ack), 32'(vecs[i].ack));
            chk($sformatf("v%0d_ce", i),  32'(bus.ce),  32'(vecs[i].ce));
            chk($sformatf("v%0d_d", i),   32'(bus.d),   32'(vecs[i].d));
            sb.push_back('{vecs[i].gnt, vecs[i].q, vecs[i].owner, vecs[i].busy});
            edge_sample();
            got_p = '{bus.gnt, bus.q, bus.owner, bus.busy};
            if (sb.size() == 0) begin
                chk($sformatf("v%0d_sb_empty", i), 32'd0, 32'd1);
            end else begin
                exp_p = sb.pop_front();
                chk($sformatf("v%0d_gnt", i),   32'(got_p.gnt),   32'(exp_p.gnt));
                chk($sformatf("v%0d_q", i),     32'(got_p.q),     32'(exp_p.q));
                chk($sformatf("v%0d_owner", i), 32'(got_p.owner), 32'(exp_p.owner));
                chk($sformatf("v%0d_busy", i),  32'(got_p.busy),  32'(exp_p.busy));
            end
        end

        // Rotation: all four request continuously from reset.
        rot[0] = 2'd0; rot[1] = 2'd1; rot[2] = 2'd2; rot[3] = 2'd3; rot[4] = 2'd0;
        reset_dut();
        for (int p = 0; p < 5; p++) begin
            drive(4'b1111, 8'(8'h00 + p), 8'(8'h10 + p), 8'(8'h20 + p), 8'(8'h30 + p));
            edge_sample();
            chk($sformatf("rot%0d_gnt", p),   32'(bus.gnt),   32'(4'b0001 << rot[p]));
            chk($sformatf("rot%0d_owner", p), 32'(bus.owner), 32'(rot[p]));
            for (int w = 1; w <= 4; w++) begin
                edge_sample();
                chk($sformatf("rot%0d_w%0d_q", p, w), 32'(bus.q), 32'(8'h10 * rot[p] + p));
                chk($sformatf("rot%0d_w%0d_gnt", p, w), 32'(bus.gnt),
                    (w == 4) ? 32'h0 : 32'(4'b0001 << rot[p]));
            end
        end

        // Mid-grant reset during the second write of a burst.
        reset_dut();
        drive(4'b0100, 8'h00, 8'h00, 8'h5A, 8'h00);
        edge_sample();
        chk("mr_gnt2", 32'(bus.gnt), 32'b0100);
        edge_sample();
        chk("mr_q1", 32'(bus.q), 32'h5A);
        drive(4'b0101, 8'h77, 8'h00, 8'h6B, 8'h00);
        #2 clr_n = 1'b0;
        #1;
        chk("mr_q_async",    32'(bus.q),    32'h0);
        chk("mr_gnt_async",  32'(bus.gnt),  32'h0);
        chk("mr_busy_async", 32'(bus.busy), 32'h0);
        chk("mr_ce_async",   32'(bus.ce),   32'h0);
        #2 clr_n = 1'b1;
        edge_sample();
        chk("mr_regrant", 32'(bus.gnt), 32'b0001);
        chk("mr_q_hold",  32'(bus.q),   32'h0);
        edge_sample();
        chk("mr_first_write", 32'(bus.q), 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
